// File: rtl/instr_fetch.sv
// Multi-cycle instruction fetch unit: FETCH/WAIT/DECODE/UPDATE sequencing, PC
// selection and IR capture, with a sticky FAULT on memory timeout or misaligned jr.
module instr_fetch #(
  parameter logic [31:0] START_ADDR = 32'h0000_0000,
  parameter int          MAX_WAIT   = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        PCsrc,
  input  logic        Branch,
  input  logic        J_type,
  input  logic [31:0] jr_data,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [31:0] imm_ext,
  output logic        instr_valid,
  output logic        fault
);

  localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);
  localparam logic [WCW-1:0] WAIT_ONE   = WCW'(1);
  localparam logic [WCW-1:0] WAIT_ZERO  = WCW'(0);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_WAIT   = 3'd1,
    S_DECODE = 3'd2,
    S_UPDATE = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t         state_r;
  state_t         state_next_s;
  logic [31:0]    pc_r;
  logic [31:0]    pc_next_s;
  logic [31:0]    ir_r;
  logic [31:0]    ir_next_s;
  logic [WCW-1:0] wait_cnt_r;
  logic [WCW-1:0] wait_cnt_next_s;
  logic [31:0]    imm_ext_s;
  logic [31:0]    pc4_s;
  logic [31:0]    br_tgt_s;
  logic [31:0]    jmp_tgt_s;
  logic [31:0]    target_s;
  logic           jr_misaligned_s;
  logic           req_r;
  logic           valid_r;
  logic           fault_r;

  assign imm_ext_s       = {{16{ir_r[15]}}, ir_r[15:0]};
  assign pc4_s           = pc_r + 32'd4;
  assign br_tgt_s        = pc4_s + {imm_ext_s[29:0], 2'b00};
  assign jmp_tgt_s       = {pc4_s[31:28], ir_r[25:0], 2'b00};
  assign jr_misaligned_s = PCsrc && J_type && (jr_data[1:0] != 2'b00);

  // Next-PC select; J_type outranks Branch, which outranks the plain jump.
  always_comb begin
    target_s = pc4_s;
    if (!PCsrc) begin
      target_s = pc4_s;
    end else if (J_type) begin
      target_s = jr_data;
    end else if (Branch) begin
      target_s = br_tgt_s;
    end else begin
      target_s = jmp_tgt_s;
    end
  end

  // Next-state and datapath update logic; an illegal encoding falls into FAULT.
  always_comb begin
    state_next_s    = state_r;
    pc_next_s       = pc_r;
    ir_next_s       = ir_r;
    wait_cnt_next_s = wait_cnt_r;
    case (state_r)
      S_FETCH: begin
        wait_cnt_next_s = WAIT_ZERO;
        state_next_s    = S_WAIT;
      end
      S_WAIT: begin
        if (imem_ready) begin
          ir_next_s       = imem_rdata;
          wait_cnt_next_s = WAIT_ZERO;
          state_next_s    = S_DECODE;
        end else if (wait_cnt_r == WAIT_LIMIT) begin
          state_next_s = S_FAULT;
        end else begin
          wait_cnt_next_s = wait_cnt_r + WAIT_ONE;
        end
      end
      S_DECODE: begin
        state_next_s = S_UPDATE;
      end
      S_UPDATE: begin
        if (jr_misaligned_s) begin
          state_next_s = S_FAULT;
        end else begin
          pc_next_s    = target_s;
          state_next_s = S_FETCH;
        end
      end
      S_FAULT: begin
        state_next_s = S_FAULT;
      end
      default: begin
        state_next_s = S_FAULT;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_FETCH;
      pc_r       <= START_ADDR;
      ir_r       <= 32'h0000_0000;
      wait_cnt_r <= WAIT_ZERO;
    end else begin
      state_r    <= state_next_s;
      pc_r       <= pc_next_s;
      ir_r       <= ir_next_s;
      wait_cnt_r <= wait_cnt_next_s;
    end
  end

  // Moore outputs registered from the next state so they track the current state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_r   <= 1'b1;
      valid_r <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      req_r   <= (state_next_s == S_FETCH) || (state_next_s == S_WAIT);
      valid_r <= (state_next_s == S_DECODE);
      fault_r <= (state_next_s == S_FAULT);
    end
  end

  assign imem_req    = req_r;
  assign instr_valid = valid_r;
  assign fault       = fault_r;
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign instr       = ir_r;
  assign op          = ir_r[31:26];
  assign func        = ir_r[5:0];
  assign imm_ext     = imm_ext_s;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised scoreboard bench for instr_fetch: a scripted memory/controller driver
// pushes expectations, a monitor checks every instr_valid pulse against them.
module tb_instr_fetch;

  localparam logic [31:0] START = 32'h0000_0000;
  localparam int          MAXW  = 15;

  logic        clk;
  logic        rst;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        PCsrc;
  logic        Branch;
  logic        J_type;
  logic [31:0] jr_data;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  func;
  logic [31:0] imm_ext;
  logic        instr_valid;
  logic        fault;

  instr_fetch #(.START_ADDR(START), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .PCsrc(PCsrc), .Branch(Branch), .J_type(J_type), .jr_data(jr_data),
    .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc), .instr(instr),
    .op(op), .func(func), .imm_ext(imm_ext), .instr_valid(instr_valid), .fault(fault)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    int          cpi;
  } item_t;

  item_t       sb_q[$];
  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] exp_pc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference next-PC computed directly from the selection rules.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w,
                                           input logic s, input logic b, input logic j,
                                           input logic [31:0] jr);
    logic [31:0] p4, off;
    p4  = p + 32'd4;
    off = {{16{w[15]}}, w[15:0]};
    if (!s)     return p4;
    else if (j) return jr;
    else if (b) return p4 + off * 32'd4;
    else        return (p4 & 32'hF000_0000) | ({6'd0, w[25:0]} * 32'd4);
  endfunction

  task automatic garbage_ctrl();
    PCsrc   = 1'($urandom_range(0, 1));
    Branch  = 1'($urandom_range(0, 1));
    J_type  = 1'($urandom_range(0, 1));
    jr_data = $urandom;
  endtask

  // One full instruction: FETCH, waits idle WAIT cycles, ready WAIT, DECODE, UPDATE.
  task automatic do_instr(input logic [31:0] w, input int waits, input logic s,
                          input logic b, input logic j, input logic [31:0] jr,
                          input logic chk_cpi, input logic use_lit, input logic [31:0] lit);
    item_t it;
    chk("req_fetch", {31'd0, imem_req}, 32'd1);
    imem_ready = 1'($urandom_range(0, 1));
    imem_rdata = $urandom;
    garbage_ctrl();
    @(negedge clk);
    for (int i = 0; i < waits; i++) begin
      chk("req_wait", {31'd0, imem_req}, 32'd1);
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      garbage_ctrl();
      @(negedge clk);
    end
    chk("req_wait_rdy", {31'd0, imem_req}, 32'd1);
    imem_ready = 1'b1;
    imem_rdata = w;
    it.pc   = exp_pc;
    it.word = w;
    it.cpi  = chk_cpi ? 4 + waits : 0;
    sb_q.push_back(it);
    @(negedge clk);
    chk("req_decode", {31'd0, imem_req}, 32'd0);
    imem_ready = 1'($urandom_range(0, 1));
    imem_rdata = $urandom;
    garbage_ctrl();
    @(negedge clk);
    chk("req_update", {31'd0, imem_req}, 32'd0);
    chk("fault_update", {31'd0, fault}, 32'd0);
    imem_ready = 1'($urandom_range(0, 1));
    imem_rdata = $urandom;
    PCsrc   = s;
    Branch  = b;
    J_type  = j;
    jr_data = jr;
    exp_pc  = use_lit ? lit : ref_next(exp_pc, w, s, b, j, jr);
    @(negedge clk);
    garbage_ctrl();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_pc", pc, START);
    chk("rst_ir", instr, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    rst    = 1'b1;
    exp_pc = START;
  endtask

  // Monitor: every instr_valid pulse pops one expectation.
  initial begin
    item_t it;
    int    cyc = 0;
    int    last = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst && instr_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          it = sb_q.pop_front();
          chk("mon_pc", pc, it.pc);
          chk("mon_addr", imem_addr, it.pc);
          chk("mon_instr", instr, it.word);
          chk("mon_op", {26'd0, op}, {26'd0, it.word[31:26]});
          chk("mon_func", {26'd0, func}, {26'd0, it.word[5:0]});
          chk("mon_imm", imm_ext, {{16{it.word[15]}}, it.word[15:0]});
          if (it.cpi != 0) chk("mon_cpi", cyc - last, it.cpi);
        end
        last = cyc;
      end
    end
  end

  initial begin
    logic [31:0] w, jr, saved_pc;
    int          wt;
    logic        s, b, j;
    rst        = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    garbage_ctrl();
    exp_pc = START;
    repeat (3) @(negedge clk);
    chk("init_pc", pc, START);
    chk("init_ir", instr, 32'd0);
    chk("init_req", {31'd0, imem_req}, 32'd1);
    chk("init_fault", {31'd0, fault}, 32'd0);
    chk("init_valid", {31'd0, instr_valid}, 32'd0);
    rst = 1'b1;

    // Directed: sequential, CPI 7, branches, jump, jr, wrap.
    do_instr(32'h1111_0001, 0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0004);
    do_instr(32'h2222_0002, 0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0008);
    do_instr(32'h3333_0003, 3, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_000C);
    do_instr(32'h0000_0008, 0, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 1'b1, 32'h0000_0010);
    do_instr(32'h1234_FFFE, 0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_000C);
    do_instr(32'h0000_0008, 1, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 1'b1, 32'h0000_0010);
    do_instr(32'h1234_0003, 0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0020);
    do_instr(32'h0000_0008, 0, 1'b1, 1'b1, 1'b1, 32'h1000_0000, 1'b1, 1'b1, 32'h1000_0000);
    do_instr({6'h02, 26'h000_0040}, 0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h1000_0100);
    do_instr(32'h0000_0008, 2, 1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1, 32'h0000_0200);
    do_instr(32'h0000_0008, 0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'hFFFF_FFFC);
    do_instr(32'hCAFE_0001, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0000);

    // Random instructions checked against the reference model.
    for (int k = 0; k < 40; k++) begin
      w  = $urandom | 32'd1;
      wt = $urandom_range(0, 4);
      s  = 1'($urandom_range(0, 1));
      b  = 1'($urandom_range(0, 1));
      j  = 1'($urandom_range(0, 1));
      jr = $urandom & 32'hFFFF_FFFC;
      do_instr(w, wt, s, b, j, jr, 1'b1, 1'b0, 32'd0);
    end

    // Reset asserted mid-WAIT while ready is high must drop the fetch.
    imem_ready = 1'b0;
    @(negedge clk);
    imem_ready = 1'b0;
    @(negedge clk);
    imem_ready = 1'b1;
    imem_rdata = 32'h1357_9BDF;
    do_reset();
    chk("midwait_ir", instr, 32'd0);
    chk("midwait_req", {31'd0, imem_req}, 32'd1);
    do_instr(32'h0246_8ACE, 0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, START + 32'd4);

    // Misaligned jr faults with pc and IR frozen.
    saved_pc = exp_pc;
    do_instr(32'hA5A5_0F0F, 0, 1'b1, 1'b0, 1'b1, 32'h0000_0201, 1'b1, 1'b1, saved_pc);
    for (int k = 0; k < 4; k++) begin
      imem_ready = 1'b1;
      imem_rdata = $urandom;
      garbage_ctrl();
      chk("jrf_fault", {31'd0, fault}, 32'd1);
      chk("jrf_req", {31'd0, imem_req}, 32'd0);
      chk("jrf_valid", {31'd0, instr_valid}, 32'd0);
      chk("jrf_pc", pc, saved_pc);
      chk("jrf_ir", instr, 32'hA5A5_0F0F);
      @(negedge clk);
    end

    // Timeout: MAX_WAIT+1 idle WAIT cycles, fault on the last edge.
    do_reset();
    imem_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= MAXW; k++) begin
      chk("to_req", {31'd0, imem_req}, 32'd1);
      chk("to_fault_early", {31'd0, fault}, 32'd0);
      imem_ready = 1'b0;
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      chk("to_fault", {31'd0, fault}, 32'd1);
      chk("to_req_off", {31'd0, imem_req}, 32'd0);
      chk("to_ir", instr, 32'd0);
      chk("to_pc", pc, START);
      imem_ready = 1'b1;
      imem_rdata = $urandom;
      @(negedge clk);
    end

    // Recovery after reset starts again at START_ADDR.
    do_reset();
    chk("rec_addr", imem_addr, START);
    do_instr(32'h0BAD_F00D, 1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, START + 32'd4);
    repeat (2) @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL have parameter START_ADDR, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 The module SHALL have parameter MAX_WAIT, default 15, giving the number of WAIT cycles without imem_ready that are tolerated before a fault.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous reset, active-low; the block is held in reset while rst=0.
REQ-005 imem_ready  input  1  instruction memory data valid; sampled only in WAIT.
REQ-006 imem_rdata  input  32  instruction word from memory.
REQ-007 PCsrc, Branch, J_type  input  1 each  registered controller outputs.
REQ-008 jr_data  input  32  register-file value used as the jr target.
REQ-009 imem_req  output  1  fetch request.
REQ-010 imem_addr  output  32  fetch address; always equal to pc.
REQ-011 pc  output  32  current program counter.
REQ-012 instr  output  32  instruction register (IR).
REQ-013 op  output  6  IR[31:26], feeds the controller.
REQ-014 func  output  6  IR[5:0], feeds the controller.
REQ-015 imm_ext  output  32  sign-extended IR[15:0].
REQ-016 instr_valid  output  1  one-cycle pulse in DECODE.
REQ-017 fault  output  1  sticky error flag.

Function
REQ-018 The FSM SHALL have five states: FETCH, WAIT, DECODE, UPDATE and FAULT; the reset state SHALL be FETCH.
REQ-019 FETCH SHALL last exactly one cycle and then go to WAIT; imem_ready SHALL be ignored in FETCH.
REQ-020 imem_req SHALL be a Moore output equal to 1 in FETCH and WAIT and 0 in every other state.
REQ-021 In WAIT with imem_ready=1, the block SHALL load IR<=imem_rdata, clear wait_cnt and go to DECODE.
REQ-022 In WAIT with imem_ready=0, the block SHALL increment wait_cnt; when wait_cnt==MAX_WAIT it SHALL go to FAULT instead of incrementing.
REQ-023 In DECODE, instr_valid SHALL be 1 and IR SHALL be held; this gives the controller one rising edge to register its outputs; the next state SHALL be UPDATE.
REQ-024 In UPDATE, the block SHALL load pc<=next_pc on the closing edge and go to FETCH; PCsrc, Branch and J_type SHALL be sampled only in UPDATE.
REQ-025 pc4 SHALL equal pc+4, modulo 2^32, so that 32'hFFFF_FFFC wraps to 0.
REQ-026 next_pc SHALL be selected as follows:
- PCsrc=0 -> pc4.
- PCsrc=1 and J_type=1 -> jr_data.
- PCsrc=1, J_type=0, Branch=1 -> pc4 + (imm_ext<<2), mod 2^32.
- PCsrc=1 with J_type=0 and Branch=0 -> {pc4[31:28], IR[25:0], 2'b00}.
REQ-027 The priority of the select inputs SHALL be J_type > Branch > jump.
REQ-028 In UPDATE, if PCsrc=1, J_type=1 and jr_data[1:0]!=0, pc SHALL be left unchanged and the block SHALL go to FAULT.
REQ-029 FAULT SHALL be absorbing: fault=1, imem_req=0, instr_valid=0, and pc and IR frozen until reset.
REQ-030 Minimum cycles per instruction SHALL be 4 (FETCH, WAIT with immediate ready, DECODE, UPDATE); each extra WAIT cycle adds one.
REQ-031 op, func and imm_ext SHALL be combinational decodes of IR only.

Reset
REQ-032 On rst=0, asynchronously and independent of state, the block SHALL set: state=FETCH, pc=START_ADDR, IR=0, wait_cnt=0, fault=0, instr_valid=0.
REQ-033 Because imem_req is a Moore output, it SHALL be 1 during and immediately after reset (state FETCH).
REQ-034 A reset asserted mid-WAIT SHALL discard the pending fetch; an imem_ready arriving in the same cycle SHALL NOT load IR.
REQ-035 The first request after rst returns to 1 SHALL be to START_ADDR.

Verification
REQ-036 Sequential fetch: rst release, imem_ready=1 every WAIT, PCsrc=0 -> pc sequence 0,4,8 on every 4th cycle; instr_valid pulses every 4 cycles.
REQ-037 Branch: pc=0x10, IR[15:0]=16'hFFFE, PCsrc=1, Branch=1 -> pc=0x0C; with IR[15:0]=16'h0003 -> pc=0x20.
REQ-038 Jump and jr: pc=0x1000_0000, IR[25:0]=26'h0000040, PCsrc=1 -> pc=0x1000_0100; J_type=1 with jr_data=0x0000_0200 -> pc=0x200; jr_data=0x201 -> fault=1 and pc unchanged.
REQ-039 Wait and timeout: imem_ready held low for 3 cycles then high -> CPI=7; imem_ready held low for MAX_WAIT+1 WAIT cycles -> fault=1, imem_req=0, and the state stays until reset.
REQ-040 Wrap and reset: pc=32'hFFFF_FFFC, PCsrc=0 -> pc=0; rst pulsed low mid-WAIT with imem_ready=1 -> IR=0, pc=START_ADDR, state FETCH.
